// File: rtl/intadd_pkg.sv
// Shared encodings for the SIMD integer add/sub cell: precision codes,
// control-word field positions, status bit positions and control decode.
package intadd_pkg;

  typedef enum logic [1:0] {
    PREC_8   = 2'b00,
    PREC_16  = 2'b01,
    PREC_32  = 2'b10,
    PREC_ILL = 2'b11
  } prec_e;

  localparam int CTL_SIGN_S0 = 2;
  localparam int CTL_SIGN_S1 = 3;
  localparam int CTL_SIGN_D  = 4;
  localparam int CTL_SUB     = 5;
  localparam int CTL_SAT     = 6;
  localparam int CTL_UPD     = 7;

  localparam int ST_OVF = 0;
  localparam int ST_ILL = 1;

  typedef struct packed {
    prec_e prec;
    logic  sign_s0;
    logic  sign_s1;
    logic  sign_d;
    logic  sub;
    logic  sat;
    logic  update_st;
  } ctl_t;

  function automatic ctl_t decode_ctl(input logic [7:0] w);
    ctl_t c;
    c.prec      = prec_e'(w[1:0]);
    c.sign_s0   = w[CTL_SIGN_S0];
    c.sign_s1   = w[CTL_SIGN_S1];
    c.sign_d    = w[CTL_SIGN_D];
    c.sub       = w[CTL_SUB];
    c.sat       = w[CTL_SAT];
    c.update_st = w[CTL_UPD];
    return c;
  endfunction

endpackage

// File: rtl/intadd_lane32.sv
// One 32-bit slice of the SIMD adder: 4x8, 2x16 or 1x32 lanes with
// extension, add/sub, range check, optional clamp and per-byte overflow flags.
module intadd_lane32
  import intadd_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  ctl_t        ctl,
  output logic [31:0] res,
  output logic [3:0]  ovf
);

  // Returns {overflow, result}; operands arrive zero-padded to 32 bits and
  // only the low w bits of the result are meaningful.
  function automatic logic [32:0] lane_calc(input logic [31:0] x, input logic [31:0] y,
                                            input int w, input ctl_t c);
    logic [31:0]        wm;
    logic               ext_x, ext_y, o;
    logic signed [33:0] ex, ey, r, hi, lo;
    logic [31:0]        v;
    wm    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    ext_x = c.sign_s0 & ((w == 8) ? x[7] : (w == 16) ? x[15] : x[31]);
    ext_y = c.sign_s1 & ((w == 8) ? y[7] : (w == 16) ? y[15] : y[31]);
    ex    = {{2{ext_x}}, (x & wm) | ({32{ext_x}} & ~wm)};
    ey    = {{2{ext_y}}, (y & wm) | ({32{ext_y}} & ~wm)};
    r     = c.sub ? (ex - ey) : (ex + ey);
    hi    = c.sign_d ? $signed({2'b00, wm >> 1}) : $signed({2'b00, wm});
    lo    = c.sign_d ? (-$signed({2'b00, wm >> 1}) - 34'sd1) : 34'sd0;
    o     = (r > hi) || (r < lo);
    if (c.sat && (r > hi))      v = hi[31:0];
    else if (c.sat && (r < lo)) v = lo[31:0];
    else                        v = r[31:0];
    return {o, v & wm};
  endfunction

  always_comb begin
    logic [32:0] t;
    // NOTE: every output gets a default before the case so no path infers a latch.
    t   = '0;
    res = '0;
    ovf = '0;
    unique case (ctl.prec)
      PREC_8: begin
        for (int k = 0; k < 4; k++) begin
          t = lane_calc({24'b0, a[8*k +: 8]}, {24'b0, b[8*k +: 8]}, 8, ctl);
          res[8*k +: 8] = t[7:0];
          ovf[k]        = t[32];
        end
      end
      PREC_16: begin
        for (int j = 0; j < 2; j++) begin
          t = lane_calc({16'b0, a[16*j +: 16]}, {16'b0, b[16*j +: 16]}, 16, ctl);
          res[16*j +: 16] = t[15:0];
          ovf[2*j +: 2]   = {2{t[32]}};
        end
      end
      PREC_32: begin
        t   = lane_calc(a, b, 32, ctl);
        res = t[31:0];
        ovf = {4{t[32]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/intadd_simd.sv
// SIMD integer add/sub cell: operand register, lane datapath, output register
// with valid/ready backpressure, sticky status and saturating overflow counter.
module intadd_simd
  import intadd_pkg::*;
#(
  parameter int DW    = 128,
  parameter int CW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    src_reg0,
  input  logic [DW-1:0]    src_reg1,
  input  logic [CW-1:0]    cru_intadd,
  input  logic [4:0]       i_smc_id,
  input  logic             st_clr,
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic [DW-1:0]    dst_reg0,
  output logic [DW/8-1:0]  o_ovf_mask,
  output logic [CW-1:0]    o_cru_intadd,
  output logic [4:0]       o_smc_id,
  output logic [31:0]      st,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int NL = DW / 32;

  logic             rdy_q, rdy_d;
  logic             s1_valid_q, s1_valid_d;
  logic [DW-1:0]    s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [CW-1:0]    s1_ctl_q, s1_ctl_d;
  logic [4:0]       s1_id_q, s1_id_d;
  logic             dst_valid_q, dst_valid_d;
  logic [DW-1:0]    dst_q, dst_d;
  logic [DW/8-1:0]  mask_q, mask_d;
  logic [CW-1:0]    o_ctl_q, o_ctl_d;
  logic [4:0]       o_id_q, o_id_d;
  logic [1:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctl_t             s1_c;
  logic [DW-1:0]    lane_res;
  logic [DW/8-1:0]  lane_ovf;
  logic             stall, advance, accept, any_ovf, illegal, evt;

  assign s1_c     = decode_ctl(s1_ctl_q[7:0]);
  assign stall    = dst_valid_q && !dst_ready;
  assign advance  = !stall;
  assign in_ready = rdy_q && !stall;
  assign accept   = in_valid && in_ready;
  assign any_ovf  = |lane_ovf;
  assign illegal  = (s1_c.prec == PREC_ILL);
  assign evt      = advance && s1_valid_q && s1_c.update_st;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    intadd_lane32 u_lane (
      .a   (s1_a_q[32*g +: 32]),
      .b   (s1_b_q[32*g +: 32]),
      .ctl (s1_c),
      .res (lane_res[32*g +: 32]),
      .ovf (lane_ovf[4*g +: 4])
    );
  end

  always_comb begin
    rdy_d       = 1'b1;
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_ctl_d    = s1_ctl_q;
    s1_id_d     = s1_id_q;
    dst_valid_d = dst_valid_q;
    dst_d       = dst_q;
    mask_d      = mask_q;
    o_ctl_d     = o_ctl_q;
    o_id_d      = o_id_q;
    if (advance) begin
      s1_valid_d  = accept;
      dst_valid_d = s1_valid_q;
      if (accept) begin
        s1_a_d   = src_reg0;
        s1_b_d   = src_reg1;
        s1_ctl_d = cru_intadd;
        s1_id_d  = i_smc_id;
      end
      if (s1_valid_q) begin
        dst_d   = lane_res;
        mask_d  = lane_ovf;
        o_ctl_d = s1_ctl_q;
        o_id_d  = s1_id_q;
      end
    end
    // A clear in the same cycle as an update wipes the old state, then the new event lands.
    st_d  = st_clr ? '0 : st_q;
    cnt_d = st_clr ? '0 : cnt_q;
    if (evt) begin
      st_d[ST_OVF] = st_d[ST_OVF] | any_ovf;
      st_d[ST_ILL] = st_d[ST_ILL] | illegal;
      if (any_ovf && (cnt_d != {CNT_W{1'b1}})) cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // NOTE: every flop is reset, including the data registers, so all outputs read zero in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_ctl_q    <= '0;
      s1_id_q     <= '0;
      dst_valid_q <= 1'b0;
      dst_q       <= '0;
      mask_q      <= '0;
      o_ctl_q     <= '0;
      o_id_q      <= '0;
      st_q        <= '0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      rdy_q       <= rdy_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_ctl_q    <= s1_ctl_d;
      s1_id_q     <= s1_id_d;
      dst_valid_q <= dst_valid_d;
      dst_q       <= dst_d;
      mask_q      <= mask_d;
      o_ctl_q     <= o_ctl_d;
      o_id_q      <= o_id_d;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dst_valid    = dst_valid_q;
  assign dst_reg0     = dst_q;
  assign o_ovf_mask   = mask_q;
  assign o_cru_intadd = o_ctl_q;
  assign o_smc_id     = o_id_q;
  assign st           = {30'b0, st_q};
  assign ovf_cnt      = cnt_q;

endmodule

// File: tb/tb_intadd_simd.sv
// Directed bench for intadd_simd (DW=128): saturation/wrap, mixed signedness,
// illegal precision, status clear, backpressure ordering and mid-flight reset.
module tb_intadd_simd;

  localparam int DW    = 128;
  localparam int CW    = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    src_reg0, src_reg1;
  logic [CW-1:0]    cru_intadd;
  logic [4:0]       i_smc_id;
  logic             st_clr;
  logic             dst_valid;
  logic             dst_ready;
  logic [DW-1:0]    dst_reg0;
  logic [DW/8-1:0]  o_ovf_mask;
  logic [CW-1:0]    o_cru_intadd;
  logic [4:0]       o_smc_id;
  logic [31:0]      st;
  logic [CNT_W-1:0] ovf_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0]   r_dst;
  logic [DW/8-1:0] r_mask;
  logic [CW-1:0]   r_ctl;
  logic [4:0]      r_id;

  intadd_simd #(.DW(DW), .CW(CW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .src_reg0     (src_reg0),
    .src_reg1     (src_reg1),
    .cru_intadd   (cru_intadd),
    .i_smc_id     (i_smc_id),
    .st_clr       (st_clr),
    .dst_valid    (dst_valid),
    .dst_ready    (dst_ready),
    .dst_reg0     (dst_reg0),
    .o_ovf_mask   (o_ovf_mask),
    .o_cru_intadd (o_cru_intadd),
    .o_smc_id     (o_smc_id),
    .st           (st),
    .ovf_cnt      (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // Offers one op, waits for its result with dst_ready high, captures it.
  // clr_at_out raises st_clr on exactly the cycle the op enters the output stage.
  task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [CW-1:0] ctl, input logic [4:0] id, input bit clr_at_out);
    int n;
    @(negedge clk);
    in_valid = 1'b1; src_reg0 = a; src_reg1 = b; cru_intadd = ctl; i_smc_id = id;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
    check("accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    if (clr_at_out) st_clr = 1'b1;
    n = 0;
    while (!dst_valid && n < 10) begin @(negedge clk); st_clr = 1'b0; n++; end
    st_clr = 1'b0;
    check("result_valid", dst_valid, 1);
    r_dst = dst_reg0; r_mask = o_ovf_mask; r_ctl = o_cru_intadd; r_id = o_smc_id;
  endtask

  function automatic logic [7:0] a_byte(input int k);
    return 8'(k * 40 + 100);
  endfunction

  function automatic logic [7:0] b_byte(input int k);
    return 8'(k * 3);
  endfunction

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; dst_ready = 1'b1; st_clr = 1'b0;
    src_reg0 = '0; src_reg1 = '0; cru_intadd = '0; i_smc_id = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_dst_valid", dst_valid, 0);
    check("rst_dst", dst_reg0, '0);
    check("rst_st", st, 0);
    check("rst_cnt", ovf_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // 1: int8 signed 0x7F+0x01, saturate then wrap; upper control bits pass through
    do_op({16{8'h7F}}, {16{8'h01}}, 16'hA5DC, 5'd1, 1'b0);
    check("t1_sat_dst", r_dst, {16{8'h7F}});
    check("t1_sat_mask", r_mask, 16'hFFFF);
    check("t1_ctl_pass", r_ctl, 16'hA5DC);
    check("t1_id", r_id, 5'd1);
    check("t1_st", st, 32'h1);
    check("t1_cnt", ovf_cnt, 1);
    do_op({16{8'h7F}}, {16{8'h01}}, 16'h009C, 5'd2, 1'b0);
    check("t1_wrap_dst", r_dst, {16{8'h80}});
    check("t1_wrap_mask", r_mask, 16'hFFFF);
    check("t1_wrap_cnt", ovf_cnt, 2);

    // 2: int32 unsigned 0-1
    do_op('0, {4{32'h1}}, 16'h00E2, 5'd3, 1'b0);
    check("t2_sat_dst", r_dst, '0);
    check("t2_sat_mask", r_mask, 16'hFFFF);
    do_op('0, {4{32'h1}}, 16'h00A2, 5'd4, 1'b0);
    check("t2_wrap_dst", r_dst, {4{32'hFFFF_FFFF}});
    check("t2_wrap_mask", r_mask, 16'hFFFF);
    check("t2_st", st, 32'h1);
    check("t2_cnt", ovf_cnt, 4);

    // 3: int16 signed -1 + unsigned 1 into signed dst
    do_op({8{16'hFFFF}}, {8{16'h0001}}, 16'h0095, 5'd5, 1'b0);
    check("t3_dst", r_dst, '0);
    check("t3_mask", r_mask, 16'h0);
    check("t3_cnt", ovf_cnt, 4);

    // int8 signed 5-7 = -2, in range
    do_op({16{8'h05}}, {16{8'h07}}, 16'h00BC, 5'd6, 1'b0);
    check("s8_sub_dst", r_dst, {16{8'hFE}});
    check("s8_sub_mask", r_mask, 16'h0);

    // 5: illegal precision, then clear coinciding with an overflowing update
    do_op({16{8'h5A}}, {16{8'h33}}, 16'h0083, 5'd7, 1'b0);
    check("t5_ill_dst", r_dst, '0);
    check("t5_ill_mask", r_mask, 16'h0);
    check("t5_ill_st", st, 32'h3);
    check("t5_ill_cnt", ovf_cnt, 4);
    do_op({16{8'h7F}}, {16{8'h01}}, 16'h00DC, 5'd8, 1'b1);
    check("t5_clr_st", st, 32'h1);
    check("t5_clr_cnt", ovf_cnt, 1);
    check("t5_clr_dst", r_dst, {16{8'h7F}});

    // 4: six back-to-back ops, consumer stalls 3 cycles after the first result
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          int n;
          @(negedge clk);
          in_valid = 1'b1;
          src_reg0 = {16{a_byte(k)}}; src_reg1 = {16{b_byte(k)}};
          cru_intadd = 16'h0000; i_smc_id = 5'(10 + k);
          #1;
          n = 0;
          while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        int got, cyc, held;
        logic [DW-1:0] snap;
        got = 0; cyc = 0; held = 0; snap = '0;
        while (got < 6 && cyc < 200) begin
          @(negedge clk);
          cyc++;
          if (got == 1 && held < 3) begin
            if (held == 0) begin
              dst_ready = 1'b0;
              snap = dst_reg0;
              check("t4_stall_valid", dst_valid, 1);
            end else begin
              check("t4_stall_stable", dst_reg0, snap);
              check("t4_stall_in_ready", in_ready, 0);
            end
            held++;
          end else begin
            dst_ready = 1'b1;
            if (dst_valid) begin
              check("t4_data", dst_reg0, {16{8'(int'(a_byte(got)) + int'(b_byte(got)))}});
              check("t4_id", o_smc_id, 5'(10 + got));
              got++;
            end
          end
        end
        check("t4_count", got, 6);
      end
    join
    dst_ready = 1'b1;
    @(negedge clk);
    check("t4_cnt_untouched", ovf_cnt, 1);

    // 6: reset with two ops in flight
    @(negedge clk);
    in_valid = 1'b1; src_reg0 = {16{8'h7F}}; src_reg1 = {16{8'h01}};
    cru_intadd = 16'h00DC; i_smc_id = 5'd20;
    #1 check("t6_accept_a", in_ready, 1);
    @(negedge clk);
    i_smc_id = 5'd21;
    #1 check("t6_accept_b", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("t6_inflight", dst_valid, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", dst_valid, 0);
    check("t6_rst_st", st, 0);
    check("t6_rst_cnt", ovf_cnt, 0);
    check("t6_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (dst_valid) seen++;
    end
    check("t6_no_stale", seen, 0);
    check("t6_ready_again", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
